// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: stage enables, condition codes, cnd and status.
// Optional MEM_WAIT_EN macro: MEMORY waits on mem_ready with a WAIT_MAX-cycle timeout.
module y86_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  input  logic       instr_valid,
  input  logic       imem_error,
  input  logic       alu_zf,
  input  logic       alu_sf,
  input  logic       alu_of,
  input  logic       mem_ready,
  input  logic       dmem_error,
  output logic       fetch_en,
  output logic       decode_en,
  output logic       execute_en,
  output logic       memory_en,
  output logic       writeback_en,
  output logic       pc_en,
  output logic       mem_req,
  output logic       cc_zf,
  output logic       cc_sf,
  output logic       cc_of,
  output logic       cnd,
  output logic [1:0] stat,
  output logic       busy,
  output logic       retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  state_t     state, state_next;
  logic [1:0] stat_next;
  logic [2:0] cc_next;
  logic       cnd_next;
  logic       cond_eval;
  logic       is_cond_op;
  logic       is_mem_op;
  logic       exec_ins;

`ifdef MEM_WAIT_EN
  parameter int unsigned WAIT_MAX = 15;
  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
  logic [WAIT_W-1:0] wait_cnt, wait_next;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  // Instruction classification and jXX/cmovXX condition from the pre-update codes
  always_comb begin
    is_cond_op = (icode == 4'h2) || (icode == 4'h7);
    is_mem_op  = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                 (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);
    exec_ins   = (is_cond_op && (ifun > 4'h6)) || ((icode == 4'h6) && (ifun > 4'h3));
    case (ifun)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = (cc_sf ^ cc_of) | cc_zf;
      4'h2:    cond_eval = cc_sf ^ cc_of;
      4'h3:    cond_eval = cc_zf;
      4'h4:    cond_eval = ~cc_zf;
      4'h5:    cond_eval = ~(cc_sf ^ cc_of);
      4'h6:    cond_eval = ~(cc_sf ^ cc_of) & ~cc_zf;
      default: cond_eval = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    stat_next  = stat;
    cc_next    = {cc_zf, cc_sf, cc_of};
    cnd_next   = cnd;
`ifdef MEM_WAIT_EN
    wait_next  = '0;
`endif
    case (state)
      S_IDLE: if (run) state_next = S_FETCH;
      S_FETCH: begin
        if (instr_valid) begin
          if (imem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_HALTED;
          end else if (icode > 4'hB) begin
            stat_next  = STAT_INS;
            state_next = S_HALTED;
          end else if (icode == 4'h0) begin
            stat_next  = STAT_HLT;
            state_next = S_HALTED;
          end else begin
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: state_next = S_EXECUTE;
      S_EXECUTE: begin
        if (exec_ins) begin
          stat_next  = STAT_INS;
          state_next = S_HALTED;
        end else begin
          if (icode == 4'h6) cc_next = {alu_zf, alu_sf, alu_of};
          cnd_next   = is_cond_op ? cond_eval : 1'b0;
          state_next = is_mem_op ? S_MEMORY : S_WRITEBACK;
        end
      end
      S_MEMORY: begin
`ifdef MEM_WAIT_EN
        wait_next = wait_cnt + WAIT_W'(1);
        if (mem_ready) begin
          if (dmem_error) begin
            stat_next  = STAT_ADR;
            state_next = S_HALTED;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (wait_cnt == WAIT_W'(WAIT_MAX - 1)) begin
          stat_next  = STAT_ADR;
          state_next = S_HALTED;
        end
`else
        if (dmem_error) begin
          stat_next  = STAT_ADR;
          state_next = S_HALTED;
        end else begin
          state_next = S_WRITEBACK;
        end
`endif
      end
      S_WRITEBACK: state_next = S_PCUPD;
      S_PCUPD:     state_next = run ? S_FETCH : S_IDLE;
      S_HALTED:    state_next = S_HALTED;
      default:     state_next = S_IDLE;
    endcase
  end

  // State, architectural registers and registered decodes of the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      stat         <= STAT_AOK;
      cc_zf        <= 1'b1;
      cc_sf        <= 1'b0;
      cc_of        <= 1'b0;
      cnd          <= 1'b0;
      fetch_en     <= 1'b0;
      decode_en    <= 1'b0;
      execute_en   <= 1'b0;
      memory_en    <= 1'b0;
      writeback_en <= 1'b0;
      pc_en        <= 1'b0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      retired      <= 1'b0;
`ifdef MEM_WAIT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      state                 <= state_next;
      stat                  <= stat_next;
      {cc_zf, cc_sf, cc_of} <= cc_next;
      cnd                   <= cnd_next;
      fetch_en              <= (state_next == S_FETCH);
      decode_en             <= (state_next == S_DECODE);
      execute_en            <= (state_next == S_EXECUTE);
      memory_en             <= (state_next == S_MEMORY);
      writeback_en          <= (state_next == S_WRITEBACK);
      pc_en                 <= (state_next == S_PCUPD);
      mem_req               <= (state_next == S_MEMORY);
      busy                  <= (state_next != S_IDLE) && (state_next != S_HALTED);
      retired               <= (state_next == S_PCUPD);
`ifdef MEM_WAIT_EN
      wait_cnt              <= wait_next;
`endif
    end
  end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed self-checking bench for y86_seq_ctrl; MEM_WAIT_EN selects the wait-state scenarios.
module tb_y86_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, run, instr_valid, imem_error;
  logic [3:0] icode, ifun;
  logic       alu_zf, alu_sf, alu_of, mem_ready, dmem_error;
  logic       fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en;
  logic       mem_req, cc_zf, cc_sf, cc_of, cnd, busy, retired;
  logic [1:0] stat;
  logic [5:0] en;
  logic [2:0] cc;

  int checks = 0;
  int failures = 0;

  localparam logic [5:0] EN_0 = 6'b000000;
  localparam logic [5:0] EN_F = 6'b100000;
  localparam logic [5:0] EN_D = 6'b010000;
  localparam logic [5:0] EN_E = 6'b001000;
  localparam logic [5:0] EN_M = 6'b000100;
  localparam logic [5:0] EN_W = 6'b000010;
  localparam logic [5:0] EN_P = 6'b000001;

  assign en = {fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_en};
  assign cc = {cc_zf, cc_sf, cc_of};

  always #5 clk = ~clk;

  y86_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run), .icode(icode), .ifun(ifun),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
    .mem_ready(mem_ready), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pc_en(pc_en),
    .mem_req(mem_req), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
    .cnd(cnd), .stat(stat), .busy(busy), .retired(retired)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b1;
    tick; tick;
    checks++; if (en !== EN_0) begin failures++; $display("FAIL reset_en got=%b exp=%b", en, EN_0); end
    checks++; if ({mem_req, busy, cnd, retired} !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {mem_req, busy, cnd, retired}); end
    checks++; if (stat !== 2'd0) begin failures++; $display("FAIL reset_stat got=%0d exp=0", stat); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", cc); end
    rst_n = 1'b1; run = 1'b0;
    tick;
    checks++; if (en !== EN_0 || busy !== 1'b0) begin failures++; $display("FAIL idle_hold en=%b busy=%b exp=000000/0", en, busy); end
  endtask

  task automatic test_opq;
    icode = 4'h6; ifun = 4'h1; {alu_zf, alu_sf, alu_of} = 3'b100;
    instr_valid = 1'b0; run = 1'b1;
    tick;
    checks++; if (en !== EN_F || busy !== 1'b1) begin failures++; $display("FAIL opq_fetch en=%b busy=%b exp=%b/1", en, busy, EN_F); end
    tick;
    checks++; if (en !== EN_F) begin failures++; $display("FAIL opq_fetch_hold got=%b exp=%b", en, EN_F); end
    instr_valid = 1'b1;
    tick;
    checks++; if (en !== EN_D) begin failures++; $display("FAIL opq_decode got=%b exp=%b", en, EN_D); end
    tick;
    checks++; if (en !== EN_E) begin failures++; $display("FAIL opq_execute got=%b exp=%b", en, EN_E); end
    tick;
    checks++; if (en !== EN_W || mem_req !== 1'b0 || retired !== 1'b0) begin failures++; $display("FAIL opq_wb en=%b mem_req=%b retired=%b exp=%b/0/0", en, mem_req, retired, EN_W); end
    run = 1'b0;
    tick;
    checks++; if (en !== EN_P || retired !== 1'b1) begin failures++; $display("FAIL opq_pcupd en=%b retired=%b exp=%b/1", en, retired, EN_P); end
    tick;
    checks++; if (en !== EN_0 || retired !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL opq_idle en=%b retired=%b busy=%b exp=000000/0/0", en, retired, busy); end
    checks++; if (cc !== 3'b100) begin failures++; $display("FAIL opq_cc got=%b exp=100", cc); end
  endtask

  task automatic test_cond;
    int tv[8][3] = '{'{7, 0, 1}, '{3, 0, 0}, '{7, 2, 1}, '{7, 6, 0},
                     '{2, 3, 0}, '{2, 4, 1}, '{2, 5, 0}, '{2, 1, 1}};
    // addq producing SF=1, OF=0, ZF=0
    icode = 4'h6; ifun = 4'h0; {alu_zf, alu_sf, alu_of} = 3'b010; run = 1'b1;
    tick; tick; tick;
    run = 1'b0;
    tick;
    checks++; if (cc !== 3'b010) begin failures++; $display("FAIL cond_opq_cc got=%b exp=010", cc); end
    tick; tick;
    {alu_zf, alu_sf, alu_of} = 3'b100;
    for (int i = 0; i < 8; i++) begin
      icode = 4'(tv[i][0]); ifun = 4'(tv[i][1]); run = 1'b1;
      tick; tick; tick;
      run = 1'b0;
      tick;
      checks++; if (en !== EN_W) begin failures++; $display("FAIL cond_path[%0d] en=%b exp=%b", i, en, EN_W); end
      checks++; if (cnd !== 1'(tv[i][2])) begin failures++; $display("FAIL cond_cnd[%0d] icode=%0h ifun=%0d got=%b exp=%0d", i, icode, ifun, cnd, tv[i][2]); end
      checks++; if (cc !== 3'b010) begin failures++; $display("FAIL cond_cc_hold[%0d] got=%b exp=010", i, cc); end
      tick; tick;
    end
  endtask

  task automatic test_back_to_back;
    icode = 4'h3; ifun = 4'h0; mem_ready = 1'b1; dmem_error = 1'b0; run = 1'b1;
    tick; tick; tick; tick; tick;
    checks++; if (en !== EN_P || retired !== 1'b1) begin failures++; $display("FAIL b2b_pcupd en=%b retired=%b exp=%b/1", en, retired, EN_P); end
    icode = 4'h4;
    tick;
    checks++; if (en !== EN_F || retired !== 1'b0) begin failures++; $display("FAIL b2b_fetch en=%b retired=%b exp=%b/0", en, retired, EN_F); end
    tick; tick;
    run = 1'b0;
    tick;
    checks++; if (en !== EN_M || mem_req !== 1'b1) begin failures++; $display("FAIL b2b_mem en=%b mem_req=%b exp=%b/1", en, mem_req, EN_M); end
    tick;
    checks++; if (en !== EN_W || mem_req !== 1'b0) begin failures++; $display("FAIL b2b_wb en=%b mem_req=%b exp=%b/0", en, mem_req, EN_W); end
    tick;
    checks++; if (en !== EN_P || retired !== 1'b1) begin failures++; $display("FAIL b2b_pcupd2 en=%b retired=%b exp=%b/1", en, retired, EN_P); end
    tick;
    checks++; if (en !== EN_0) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", en, EN_0); end
  endtask

`ifdef MEM_WAIT_EN
  task automatic test_mem_wait;
    icode = 4'h5; ifun = 4'h0; mem_ready = 1'b0; dmem_error = 1'b0; run = 1'b1;
    tick; tick; tick;
    run = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++; if (en !== EN_M || mem_req !== 1'b1) begin failures++; $display("FAIL wait_mem[%0d] en=%b mem_req=%b exp=%b/1", k, en, mem_req, EN_M); end
    end
    mem_ready = 1'b1;
    tick;
    checks++; if (en !== EN_W || mem_req !== 1'b0) begin failures++; $display("FAIL wait_wb en=%b mem_req=%b exp=%b/0", en, mem_req, EN_W); end
    tick;
    checks++; if (retired !== 1'b1) begin failures++; $display("FAIL wait_retired got=%b exp=1", retired); end
    tick;
    mem_ready = 1'b0; run = 1'b1;
    tick; tick; tick;
    run = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick;
      checks++; if (en !== EN_M || stat !== 2'd0) begin failures++; $display("FAIL timeout_mem[%0d] en=%b stat=%0d exp=%b/0", k, en, stat, EN_M); end
    end
    tick;
    checks++; if (stat !== 2'd2 || en !== EN_0 || busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL timeout_halt stat=%0d en=%b busy=%b mem_req=%b exp=2/000000/0/0", stat, en, busy, mem_req); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1; mem_ready = 1'b1;
  endtask
`endif

  task automatic test_faults;
    // icode, ifun, imem_error, faults in execute, expected stat
    int fv[6][5] = '{'{12, 0, 0, 0, 3}, '{0, 0, 0, 0, 1}, '{3, 0, 1, 0, 2},
                     '{6, 4, 0, 1, 3}, '{7, 7, 0, 1, 3}, '{2, 7, 0, 1, 3}};
    for (int i = 0; i < 6; i++) begin
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      icode = 4'(fv[i][0]); ifun = 4'(fv[i][1]); imem_error = 1'(fv[i][2]); run = 1'b1;
      tick;
      checks++; if (en !== EN_F || stat !== 2'd0) begin failures++; $display("FAIL fault_fetch[%0d] en=%b stat=%0d exp=%b/0", i, en, stat, EN_F); end
      if (fv[i][3] != 0) begin
        tick; tick;
      end
      tick;
      checks++; if (stat !== 2'(fv[i][4])) begin failures++; $display("FAIL fault_stat[%0d] got=%0d exp=%0d", i, stat, fv[i][4]); end
      checks++; if (en !== EN_0 || busy !== 1'b0 || retired !== 1'b0) begin failures++; $display("FAIL fault_halt[%0d] en=%b busy=%b retired=%b exp=000000/0/0", i, en, busy, retired); end
      imem_error = 1'b0; icode = 4'h3;
      tick; tick;
      checks++; if (en !== EN_0 || stat !== 2'(fv[i][4])) begin failures++; $display("FAIL fault_frozen[%0d] en=%b stat=%0d exp=000000/%0d", i, en, stat, fv[i][4]); end
    end
    rst_n = 1'b0; run = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_dmem_err;
    icode = 4'h6; ifun = 4'h0; {alu_zf, alu_sf, alu_of} = 3'b011;
    mem_ready = 1'b1; dmem_error = 1'b0; run = 1'b1;
    tick; tick; tick;
    run = 1'b0;
    tick; tick; tick;
    checks++; if (cc !== 3'b011) begin failures++; $display("FAIL dmem_pre_cc got=%b exp=011", cc); end
    icode = 4'hA; dmem_error = 1'b1; run = 1'b1;
    tick; tick; tick;
    run = 1'b0;
    tick;
    checks++; if (en !== EN_M || stat !== 2'd0) begin failures++; $display("FAIL dmem_mem en=%b stat=%0d exp=%b/0", en, stat, EN_M); end
    tick;
    checks++; if (stat !== 2'd2 || en !== EN_0 || retired !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL dmem_halt stat=%0d en=%b retired=%b busy=%b exp=2/000000/0/0", stat, en, retired, busy); end
    rst_n = 1'b0;
    tick;
    checks++; if (stat !== 2'd0 || cc !== 3'b100 || en !== EN_0) begin failures++; $display("FAIL dmem_reset stat=%0d cc=%b en=%b exp=0/100/000000", stat, cc, en); end
    rst_n = 1'b1; dmem_error = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_mem;
    icode = 4'h5; ifun = 4'h0; mem_ready = 1'b0; run = 1'b1;
    tick; tick; tick;
    run = 1'b0;
    tick;
    checks++; if (mem_req !== 1'b1 || en !== EN_M) begin failures++; $display("FAIL midmem_req mem_req=%b en=%b exp=1/%b", mem_req, en, EN_M); end
    rst_n = 1'b0;
    tick;
    checks++; if (mem_req !== 1'b0 || en !== EN_0 || busy !== 1'b0) begin failures++; $display("FAIL midmem_reset mem_req=%b en=%b busy=%b exp=0/000000/0", mem_req, en, busy); end
    rst_n = 1'b1; run = 1'b1;
    tick;
    checks++; if (en !== EN_F) begin failures++; $display("FAIL midmem_restart got=%b exp=%b", en, EN_F); end
    run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; icode = 4'h0; ifun = 4'h0;
    instr_valid = 1'b1; imem_error = 1'b0;
    {alu_zf, alu_sf, alu_of} = 3'b000; mem_ready = 1'b1; dmem_error = 1'b0;
    test_reset;
    test_opq;
    test_cond;
    test_back_to_back;
`ifdef MEM_WAIT_EN
    test_mem_wait;
`endif
    test_faults;
    test_dmem_err;
    test_reset_mid_mem;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
